// File: rtl/uart_rx_stim.sv
// UART frame generator for the system RX line: buffered parallel words are
// serialized as start, data LSB first, optional parity, stop at PRESCALE cycles per bit.
module uart_rx_stim #(
  parameter int DATA_WIDTH = 8,
  parameter int PRESCALE_W = 6,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                  REF_CLK,
  input  logic                  RST_REF,
  input  logic [DATA_WIDTH-1:0] DATA_IN,
  input  logic                  DATA_VLD,
  output logic                  DATA_RDY,
  input  logic                  PAR_EN,
  input  logic                  PAR_TYP,
  input  logic [PRESCALE_W-1:0] PRESCALE,
  output logic                  RX_OUT,
  output logic                  busy,
  output logic [3:0]            frame_cnt
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int BIT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  // ---------------------------------------------------------------- FIFO
  logic [DATA_WIDTH-1:0] fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]      wr_ptr, rd_ptr;
  logic [CNT_W-1:0]      fifo_cnt;
  logic                  full, empty, push, pop;
  logic [DATA_WIDTH-1:0] head;

  assign full     = (fifo_cnt == CNT_W'(FIFO_DEPTH));
  assign empty    = (fifo_cnt == '0);
  assign push     = DATA_VLD && !full;
  assign DATA_RDY = !full;
  assign head     = fifo_mem[rd_ptr];

  always_ff @(posedge REF_CLK) begin
    if (push) fifo_mem[wr_ptr] <= DATA_IN;
  end

  always_ff @(posedge REF_CLK or negedge RST_REF) begin
    if (!RST_REF) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      fifo_cnt <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   fifo_cnt <= fifo_cnt + CNT_W'(1);
        2'b01:   fifo_cnt <= fifo_cnt - CNT_W'(1);
        default: fifo_cnt <= fifo_cnt;
      endcase
    end
  end

  // ----------------------------------------------------------- serializer
  state_t                state_q, state_d;
  logic [DATA_WIDTH-1:0] shift_q, shift_d;
  logic [PRESCALE_W-1:0] tick_q, tick_d;
  logic [PRESCALE_W-1:0] period_q, period_d;
  logic [BIT_W-1:0]      bit_q, bit_d;
  logic                  par_en_q, par_en_d;
  logic                  par_bit_q, par_bit_d;
  logic                  rx_d, busy_d;
  logic [3:0]            fcnt_d;
  logic                  bit_end, last_bit;

  assign bit_end  = (tick_q == period_q - PRESCALE_W'(1));
  assign last_bit = (bit_q == BIT_W'(DATA_WIDTH - 1));

  always_ff @(posedge REF_CLK or negedge RST_REF) begin
    if (!RST_REF) begin
      state_q   <= IDLE;
      shift_q   <= '0;
      tick_q    <= '0;
      period_q  <= PRESCALE_W'(1);
      bit_q     <= '0;
      par_en_q  <= 1'b0;
      par_bit_q <= 1'b0;
      RX_OUT    <= 1'b1;
      busy      <= 1'b0;
      frame_cnt <= '0;
    end else begin
      state_q   <= state_d;
      shift_q   <= shift_d;
      tick_q    <= tick_d;
      period_q  <= period_d;
      bit_q     <= bit_d;
      par_en_q  <= par_en_d;
      par_bit_q <= par_bit_d;
      RX_OUT    <= rx_d;
      busy      <= busy_d;
      frame_cnt <= fcnt_d;
    end
  end

  // RX_OUT is registered, so each branch drives the level of the bit that starts on this edge.
  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    tick_d    = tick_q + PRESCALE_W'(1);
    period_d  = period_q;
    bit_d     = bit_q;
    par_en_d  = par_en_q;
    par_bit_d = par_bit_q;
    rx_d      = RX_OUT;
    busy_d    = busy;
    fcnt_d    = frame_cnt;
    pop       = 1'b0;

    case (state_q)
      IDLE: begin
        tick_d = '0;
        rx_d   = 1'b1;
        busy_d = 1'b0;
        if (!empty) pop = 1'b1;
      end
      START: begin
        if (bit_end) begin
          tick_d  = '0;
          state_d = DATA;
          rx_d    = shift_q[0];
        end
      end
      DATA: begin
        if (bit_end) begin
          tick_d = '0;
          if (last_bit) begin
            if (par_en_q) begin
              state_d = PARITY;
              rx_d    = par_bit_q;
            end else begin
              state_d = STOP;
              rx_d    = 1'b1;
            end
          end else begin
            bit_d   = bit_q + BIT_W'(1);
            shift_d = shift_q >> 1;
            rx_d    = shift_q[1];
          end
        end
      end
      PARITY: begin
        if (bit_end) begin
          tick_d  = '0;
          state_d = STOP;
          rx_d    = 1'b1;
        end
      end
      STOP: begin
        if (bit_end) begin
          fcnt_d = frame_cnt + 4'd1;
          if (!empty) begin
            pop = 1'b1;
          end else begin
            state_d = IDLE;
            tick_d  = '0;
            rx_d    = 1'b1;
            busy_d  = 1'b0;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    // Frame start: configuration is sampled only here, so mid-frame changes are ignored.
    if (pop) begin
      state_d   = START;
      shift_d   = head;
      par_en_d  = PAR_EN;
      par_bit_d = (^head) ^ PAR_TYP;
      period_d  = (PRESCALE == '0) ? PRESCALE_W'(1) : PRESCALE;
      tick_d    = '0;
      bit_d     = '0;
      rx_d      = 1'b0;
      busy_d    = 1'b1;
    end
  end

endmodule

// File: doc/uart_rx_stim.md
Name: uart_rx_stim

Overview:
- Serial frame generator that drives the UART RX line of the system, in the REF_CLK domain.
- Accepts parallel bytes through a valid/ready handshake and buffers them in a small FIFO.
- Serializes each byte into a UART frame: start bit, data LSB first, optional parity, stop bit. Bit period is set by a configurable prescale.
- Counts completed frames so that host-to-system traffic can be paced against the TX-side flag capture.

Parameters:
DATA_WIDTH  8  width of each data word and of the serial data field
PRESCALE_W  6  width of the PRESCALE input
FIFO_DEPTH  4  number of buffered words; must be a power of 2

Ports:
REF_CLK    input   1               clock; all logic on rising edge
RST_REF    input   1               asynchronous active-low reset
DATA_IN    input   DATA_WIDTH      word to transmit
DATA_VLD   input   1               DATA_IN valid
DATA_RDY   output  1               FIFO can accept a word
PAR_EN     input   1               1 = parity bit inserted
PAR_TYP    input   1               0 = even, 1 = odd parity
PRESCALE   input   PRESCALE_W      REF_CLK cycles per serial bit
RX_OUT     output  1               serial line, idle high
busy       output  1               frame in progress
frame_cnt  output  4               completed frames, modulo 16

Behaviour:
- Reset values (asserted at any time, asynchronously):
  - RX_OUT=1, busy=0, frame_cnt=0, DATA_RDY=1.
  - FIFO emptied; FSM set to IDLE.
  - A frame in flight is abandoned. No partial stop bit; the line simply returns high.
- FIFO:
  - Push when DATA_VLD && DATA_RDY.
  - DATA_RDY = !full, where full is taken from the registered count.
  - A push offered while full is dropped, even if a pop occurs in the same cycle.
  - A simultaneous push and pop when not full leaves the count unchanged.
  - Pointers wrap modulo FIFO_DEPTH.
- FSM states: IDLE, START, DATA, PARITY, STOP.
  - IDLE: RX_OUT=1, busy=0. If the FIFO is non-empty, on the next edge:
    - pop the head word into the shift register;
    - latch PAR_EN, PAR_TYP and PRESCALE (effective bit period P = max(PRESCALE, 1));
    - go to START with RX_OUT=0 and busy=1.
  - START: hold RX_OUT=0 for P cycles, then go to DATA.
  - DATA: drive shift register bit 0 for P cycles, then shift right. After DATA_WIDTH bits go to PARITY if the latched PAR_EN=1, else to STOP.
  - PARITY: drive XOR of the word (PAR_TYP=0) or its inverse (PAR_TYP=1) for P cycles, then go to STOP.
  - STOP: RX_OUT=1 for P cycles. On the last cycle, frame_cnt increments (15 wraps to 0).
    - FIFO non-empty: go directly to START on that edge, giving back-to-back frames with no idle gap.
    - FIFO empty: go to IDLE.
- Bit-period counter counts 0..P-1 and reloads at each bit boundary.
- Config input changes mid-frame have no effect until the next frame start.
- Frame length in cycles: P*(DATA_WIDTH+2), or P*(DATA_WIDTH+3) with parity.
- Latency: a push at edge N into an empty FIFO in IDLE is popped at edge N+1; RX_OUT falls after edge N+1.
- All outputs are registered except DATA_RDY, which is decoded from the registered count.

Test Plan:
- Single byte, no parity: reset, push 0xA5 with PRESCALE=8, PAR_EN=0.
  - RX_OUT sequence per 8-cycle bit: 0,1,0,1,0,0,1,0,1,1.
  - busy high for 80 cycles; frame_cnt=1 afterwards.
- Parity types: push 0xA5 with PAR_EN=1.
  - PAR_TYP=0: parity bit 0.
  - PAR_TYP=1: parity bit 1.
  - Frame length 88 cycles at PRESCALE=8.
- FIFO full and back-to-back:
  - Hold DATA_VLD with 0x01..0x06 while idle at PRESCALE=4.
  - First pop frees a slot one cycle after the first push. 5 words are accepted (0x01..0x05); DATA_RDY drops once 4 are held; 0x06 is not accepted while DATA_RDY is low.
  - Frames are emitted in order, back-to-back, with no idle cycle between stop and start.
- PRESCALE edge cases:
  - PRESCALE=0 and PRESCALE=1 both give 1-cycle bits (10-cycle frame).
  - Changing PRESCALE mid-frame leaves the current frame timing unchanged.
- frame_cnt wrap: send 16 frames; frame_cnt goes 15 then 0.
- Reset mid-frame:
  - Assert RST_REF during the DATA state with 3 words queued.
  - RX_OUT=1, busy=0, frame_cnt=0, DATA_RDY=1 immediately.
  - No frame is emitted after release.
